// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file: enable levels,
// clear-FSM state encodings and the state enum built from them.
// Included first so the macros are visible to every later file.
`ifndef REGFILE_MP_DEFINES
`define REGFILE_MP_DEFINES
`define ENABLE        1'b1
`define DISABLE       1'b0
`define CLR_IDLE_ENC  1'b0
`define CLR_SWEEP_ENC 1'b1
`endif

package regfile_mp_pkg;

  // Clear sequencer: IDLE accepts traffic, SWEEP zeroes one register per cycle.
  typedef enum logic {
    CLR_IDLE  = `CLR_IDLE_ENC,
    CLR_SWEEP = `CLR_SWEEP_ENC
  } clr_state_e;

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Pending scoreboard: one bit per register, set by reserve, cleared by writes/sweep.
// Latency: updates visible one cycle after the request edge.
// No backpressure: every request is applied in the cycle it is presented.
module rf_scoreboard #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_i,
  input  logic [ADDR_W-1:0] set_addr_i,
  input  logic              clr0_i,
  input  logic [ADDR_W-1:0] clr0_addr_i,
  input  logic              clr1_i,
  input  logic [ADDR_W-1:0] clr1_addr_i,
  input  logic              sweep_i,
  input  logic [ADDR_W-1:0] sweep_addr_i,
  output logic [DEPTH-1:0]  pending_o
);

  logic [DEPTH-1:0] pend_q, pend_d;

  // Next pending state: clears first so a same-cycle reserve keeps the bit set.
  always_comb begin
    pend_d = pend_q;
    if (clr0_i)  pend_d[clr0_addr_i]  = 1'b0;
    if (clr1_i)  pend_d[clr1_addr_i]  = 1'b0;
    if (sweep_i) pend_d[sweep_addr_i] = 1'b0;
    if (set_i)   pend_d[set_addr_i]   = 1'b1;
    pend_d[0] = 1'b0;
  end

  // Pending register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  assign pending_o = pend_q;

endmodule

// File: rtl/regfile_mp.sv
// Register file: NUM_RD combinational read ports, two write ports, reserve scoreboard, clear sweep.
// Latency: reads combinational with write bypass; writes land on the next rising edge.
// No backpressure; while a sweep runs (clr_busy) writes, reserves and clr_req are dropped.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic [DEPTH-1:0]         pending,
  input  logic                     clr_req,
  output logic                     clr_busy
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              idle, sweep, we0, we1, rsv_ok;

  // Register 0 is hard-wired to zero, so traffic addressed to it is discarded here.
  assign idle   = (state_q == CLR_IDLE);
  assign sweep  = (state_q == CLR_SWEEP);
  assign we0    = idle && (wr0_en == `ENABLE) && (wr0_addr != '0);
  assign we1    = idle && (wr1_en == `ENABLE) && (wr1_addr != '0);
  assign rsv_ok = idle && (rsv_en == `ENABLE) && (rsv_addr != '0);

  // Clear FSM state and sweep index register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLR_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Clear FSM next state: index starts at 1 and holds at DEPTH-1 on exit, never wrapping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLR_IDLE: begin
        if (clr_req == `ENABLE) begin
          state_d = CLR_SWEEP;
          cnt_d   = ADDR_W'(1);
        end
      end
      CLR_SWEEP: begin
        if (cnt_q == LAST_IDX) state_d = CLR_IDLE;
        else                   cnt_d   = cnt_q + ADDR_W'(1);
      end
      default: state_d = CLR_IDLE;
    endcase
  end

  // Storage next state: wr1 applied after wr0 so it wins on an address collision.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    if (sweep) mem_d[cnt_q]    = '0;
    if (we0)   mem_d[wr0_addr] = wr0_data;
    if (we1)   mem_d[wr1_addr] = wr1_data;
    mem_d[0] = '0;
  end

  // Storage array with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  // Read ports: bypass from in-flight writes (wr1 first), none during a sweep since we0/we1 are gated.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = rd_addr[k*ADDR_W +: ADDR_W];
    assign rd_data[k*DATA_W +: DATA_W] = (we1 && (ra == wr1_addr)) ? wr1_data :
                                         (we0 && (ra == wr0_addr)) ? wr0_data :
                                         mem_q[ra];
  end

  rf_scoreboard #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .set_i        (rsv_ok),
    .set_addr_i   (rsv_addr),
    .clr0_i       (we0),
    .clr0_addr_i  (wr0_addr),
    .clr1_i       (we1),
    .clr1_addr_i  (wr1_addr),
    .sweep_i      (sweep),
    .sweep_addr_i (cnt_q),
    .pending_o    (pending)
  );

  assign clr_busy = sweep;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp against an array-based reference model.
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int D  = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic             clk;
  logic             rst_n;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic             wr0_en, wr1_en, rsv_en, clr_req;
  logic [AW-1:0]    wr0_addr, wr1_addr, rsv_addr;
  logic [DW-1:0]    wr0_data, wr1_data;
  logic [D-1:0]     pending;
  logic             clr_busy;

  regfile_mp #(.DATA_W(DW), .DEPTH(D), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pending(pending),
    .clr_req(clr_req), .clr_busy(clr_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model
  logic [DW-1:0] m_mem [D];
  logic [D-1:0]  m_pend;
  bit            m_busy;
  int            m_idx;
  int            vec;
  int            errs;

  task automatic model_reset();
    for (int i = 0; i < D; i++) m_mem[i] = '0;
    m_pend = '0;
    m_busy = 0;
    m_idx  = 0;
  endtask

  task automatic drive_idle();
    wr0_en = 0; wr1_en = 0; rsv_en = 0; clr_req = 0;
    wr0_addr = '0; wr1_addr = '0; rsv_addr = '0;
    wr0_data = '0; wr1_data = '0;
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (!m_busy && wr1_en && wr1_addr != 0 && a == wr1_addr) return wr1_data;
    if (!m_busy && wr0_en && wr0_addr != 0 && a == wr0_addr) return wr0_data;
    return m_mem[a];
  endfunction

  // Advance one clock: model follows the behavioural rules, then settle past the edge.
  task automatic tick();
    @(posedge clk);
    if (m_busy) begin
      m_mem[m_idx]  = '0;
      m_pend[m_idx] = 1'b0;
      m_idx++;
      if (m_idx == D) m_busy = 0;
    end else begin
      if (wr0_en && wr0_addr != 0) begin m_mem[wr0_addr] = wr0_data; m_pend[wr0_addr] = 1'b0; end
      if (wr1_en && wr1_addr != 0) begin m_mem[wr1_addr] = wr1_data; m_pend[wr1_addr] = 1'b0; end
      if (rsv_en && rsv_addr != 0) m_pend[rsv_addr] = 1'b1;
      if (clr_req) begin m_busy = 1; m_idx = 1; end
    end
    #1;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic test_reset();
    set_rd(5'd5, 5'd31);
    #1;
    vec++; if (pending !== '0) begin errs++; $display("FAIL reset_pending got=%h exp=0", pending); end
    vec++; if (clr_busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", clr_busy); end
    vec++; if (rd_data !== '0) begin errs++; $display("FAIL reset_rd got=%h exp=0", rd_data); end
    // release away from an edge and write on the very first edge
    @(negedge clk);
    rst_n = 1'b1;
    wr0_en = 1; wr0_addr = 5'd2; wr0_data = 32'h0000_00A5;
    tick();
    drive_idle();
    set_rd(5'd2, 5'd2);
    #1;
    vec++; if (rd_data[DW-1:0] !== 32'h0000_00A5) begin errs++; $display("FAIL first_edge_write got=%h exp=000000a5", rd_data[DW-1:0]); end
  endtask

  task automatic test_basic_write();
    wr0_en = 1; wr0_addr = 5'd5; wr0_data = 32'hDEAD_BEEF;
    tick();
    drive_idle();
    set_rd(5'd5, 5'd5);
    #1;
    vec++; if (rd_data[DW-1:0] !== 32'hDEAD_BEEF) begin errs++; $display("FAIL r5_port0 got=%h exp=deadbeef", rd_data[DW-1:0]); end
    vec++; if (rd_data[2*DW-1:DW] !== 32'hDEAD_BEEF) begin errs++; $display("FAIL r5_port1 got=%h exp=deadbeef", rd_data[2*DW-1:DW]); end
  endtask

  task automatic test_same_addr();
    wr0_en = 1; wr0_addr = 5'd7; wr0_data = 32'h11;
    wr1_en = 1; wr1_addr = 5'd7; wr1_data = 32'h22;
    set_rd(5'd7, 5'd7);
    #1;
    vec++; if (rd_data[DW-1:0] !== 32'h22) begin errs++; $display("FAIL bypass_wr1 got=%h exp=22", rd_data[DW-1:0]); end
    tick();
    drive_idle();
    #1;
    vec++; if (rd_data[2*DW-1:DW] !== 32'h22) begin errs++; $display("FAIL r7_after got=%h exp=22", rd_data[2*DW-1:DW]); end
  endtask

  task automatic test_r0();
    wr0_en = 1; wr0_addr = 5'd0; wr0_data = 32'hFFFF_FFFF;
    set_rd(5'd0, 5'd0);
    #1;
    vec++; if (rd_data[DW-1:0] !== '0) begin errs++; $display("FAIL r0_bypass got=%h exp=0", rd_data[DW-1:0]); end
    tick();
    drive_idle();
    rsv_en = 1; rsv_addr = 5'd0;
    tick();
    drive_idle();
    #1;
    vec++; if (rd_data[DW-1:0] !== '0) begin errs++; $display("FAIL r0_read got=%h exp=0", rd_data[DW-1:0]); end
    vec++; if (pending[0] !== 1'b0) begin errs++; $display("FAIL r0_pending got=%b exp=0", pending[0]); end
  endtask

  task automatic test_reserve();
    rsv_en = 1; rsv_addr = 5'd3;
    tick();
    drive_idle();
    vec++; if (pending[3] !== 1'b1) begin errs++; $display("FAIL rsv3_set got=%b exp=1", pending[3]); end
    wr0_en = 1; wr0_addr = 5'd3; wr0_data = 32'h3333;
    tick();
    drive_idle();
    vec++; if (pending[3] !== 1'b0) begin errs++; $display("FAIL rsv3_clear got=%b exp=0", pending[3]); end
    rsv_en = 1; rsv_addr = 5'd4;
    wr1_en = 1; wr1_addr = 5'd4; wr1_data = 32'h4444_0004;
    tick();
    drive_idle();
    set_rd(5'd4, 5'd3);
    #1;
    vec++; if (pending[4] !== 1'b1) begin errs++; $display("FAIL rsv_wr4_pending got=%b exp=1", pending[4]); end
    vec++; if (rd_data[DW-1:0] !== 32'h4444_0004) begin errs++; $display("FAIL rsv_wr4_data got=%h exp=44440004", rd_data[DW-1:0]); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      wr0_en   = ($urandom_range(0, 2) != 0);
      wr1_en   = ($urandom_range(0, 2) == 0);
      rsv_en   = ($urandom_range(0, 3) == 0);
      clr_req  = ($urandom_range(0, 59) == 0);
      wr0_addr = AW'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(0, D - 1));
      wr1_addr = ($urandom_range(0, 3) == 0) ? wr0_addr : AW'($urandom_range(0, D - 1));
      rsv_addr = ($urandom_range(0, 3) == 0) ? wr0_addr : AW'($urandom_range(0, D - 1));
      wr0_data = $urandom;
      wr1_data = $urandom;
      set_rd(($urandom_range(0, 1) != 0) ? wr1_addr : AW'($urandom_range(0, D - 1)),
             ($urandom_range(0, 1) != 0) ? wr0_addr : AW'($urandom_range(0, D - 1)));
      #1;
      vec++; if (rd_data[DW-1:0] !== exp_rd(rd_addr[AW-1:0])) begin errs++; $display("FAIL rand_rd0 n=%0d got=%h exp=%h", n, rd_data[DW-1:0], exp_rd(rd_addr[AW-1:0])); end
      vec++; if (rd_data[2*DW-1:DW] !== exp_rd(rd_addr[2*AW-1:AW])) begin errs++; $display("FAIL rand_rd1 n=%0d got=%h exp=%h", n, rd_data[2*DW-1:DW], exp_rd(rd_addr[2*AW-1:AW])); end
      tick();
      vec++; if (pending !== m_pend) begin errs++; $display("FAIL rand_pending n=%0d got=%h exp=%h", n, pending, m_pend); end
      vec++; if (clr_busy !== m_busy) begin errs++; $display("FAIL rand_busy n=%0d got=%b exp=%b", n, clr_busy, m_busy); end
    end
    drive_idle();
    for (int n = 0; n < 40 && m_busy; n++) tick();
  endtask

  task automatic test_sweep();
    int busy_cycles;
    for (int i = 1; i < D; i++) begin
      wr0_en = 1; wr0_addr = AW'(i); wr0_data = $urandom | 32'h1;
      rsv_en = 1; rsv_addr = AW'(i);
      tick();
    end
    drive_idle();
    vec++; if (pending !== m_pend) begin errs++; $display("FAIL fill_pending got=%h exp=%h", pending, m_pend); end
    clr_req = 1;
    tick();
    drive_idle();
    busy_cycles = 0;
    for (int c = 0; c < 40 && clr_busy === 1'b1; c++) begin
      busy_cycles++;
      if (c == 5) begin
        wr0_en = 1; wr0_addr = 5'd20; wr0_data = 32'h1234_5678;
        wr1_en = 1; wr1_addr = 5'd25; wr1_data = 32'h8765_4321;
        rsv_en = 1; rsv_addr = 5'd22;
        clr_req = 1;
        set_rd(5'd25, 5'd20);
        #1;
        vec++; if (rd_data[DW-1:0] !== m_mem[25]) begin errs++; $display("FAIL sweep_no_bypass got=%h exp=%h", rd_data[DW-1:0], m_mem[25]); end
      end
      tick();
      drive_idle();
    end
    vec++; if (busy_cycles !== D - 1) begin errs++; $display("FAIL sweep_len got=%0d exp=%0d", busy_cycles, D - 1); end
    vec++; if (pending !== '0) begin errs++; $display("FAIL sweep_pending got=%h exp=0", pending); end
    for (int i = 0; i < D; i += 2) begin
      set_rd(AW'(i), AW'(i + 1));
      #1;
      vec++; if (rd_data !== '0) begin errs++; $display("FAIL sweep_zero r%0d got=%h exp=0", i, rd_data); end
    end
    // a sweep must not be restarted by the clr_req that arrived mid-sweep
    tick();
    vec++; if (clr_busy !== 1'b0) begin errs++; $display("FAIL sweep_restart got=%b exp=0", clr_busy); end
  endtask

  task automatic test_reset_mid_sweep();
    wr0_en = 1; wr0_addr = 5'd20; wr0_data = 32'hAAAA_0020;
    wr1_en = 1; wr1_addr = 5'd31; wr1_data = 32'hBBBB_0031;
    rsv_en = 1; rsv_addr = 5'd29;
    tick();
    drive_idle();
    clr_req = 1;
    tick();
    drive_idle();
    for (int c = 0; c < 10; c++) tick();
    vec++; if (clr_busy !== 1'b1) begin errs++; $display("FAIL pre_abort_busy got=%b exp=1", clr_busy); end
    set_rd(5'd20, 5'd31);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    vec++; if (clr_busy !== 1'b0) begin errs++; $display("FAIL abort_busy got=%b exp=0", clr_busy); end
    vec++; if (pending !== '0) begin errs++; $display("FAIL abort_pending got=%h exp=0", pending); end
    vec++; if (rd_data !== '0) begin errs++; $display("FAIL abort_rd got=%h exp=0", rd_data); end
    @(negedge clk);
    rst_n = 1'b1;
    wr1_en = 1; wr1_addr = 5'd31; wr1_data = 32'h0BAD_CAFE;
    tick();
    drive_idle();
    #1;
    vec++; if (rd_data[2*DW-1:DW] !== 32'h0BAD_CAFE) begin errs++; $display("FAIL post_reset_write got=%h exp=0badcafe", rd_data[2*DW-1:DW]); end
    vec++; if (rd_data[DW-1:0] !== '0) begin errs++; $display("FAIL post_reset_r20 got=%h exp=0", rd_data[DW-1:0]); end
    vec++; if (clr_busy !== 1'b0) begin errs++; $display("FAIL post_reset_busy got=%b exp=0", clr_busy); end
  endtask

  initial begin
    vec = 0;
    errs = 0;
    rst_n = 1'b0;
    drive_idle();
    rd_addr = '0;
    model_reset();
    #12;
    test_reset();
    test_basic_write();
    test_same_addr();
    test_r0();
    test_reserve();
    test_random();
    test_sweep();
    test_reset_mid_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

endmodule
